// File: rtl/pong_link_pkg.sv
// Shared definitions for the pong link frame: byte count, marker position,
// field slices of the 32-bit frame and the receiver state encoding.
package pong_link_pkg;

  localparam int unsigned FRAME_BYTES = 4;
  localparam int unsigned MARKER_BIT  = 7;

  localparam int unsigned Y_P2_MSB   = 30;
  localparam int unsigned Y_P2_LSB   = 21;
  localparam int unsigned Y_BALL_MSB = 20;
  localparam int unsigned Y_BALL_LSB = 11;
  localparam int unsigned X_BALL_MSB = 10;
  localparam int unsigned X_BALL_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    PUBLISH
  } rx_state_e;

endpackage

// File: rtl/uart_frame_rx_if.sv
// Byte-in / frame-out bundle of the frame receiver. The slave side is the
// receiver; the master side feeds bytes and consumes the published frame.
interface uart_frame_rx_if;

  logic [7:0]  rx_data;
  logic        rx_done;
  logic [31:0] rx_buf;
  logic [9:0]  y_player2;
  logic [9:0]  y_ball;
  logic [10:0] x_ball;
  logic        frame_valid;
  logic        frame_err;
  logic        link_up;

  modport master (
    output rx_data, rx_done,
    input  rx_buf, y_player2, y_ball, x_ball, frame_valid, frame_err, link_up
  );

  modport slave (
    input  rx_data, rx_done,
    output rx_buf, y_player2, y_ball, x_ball, frame_valid, frame_err, link_up
  );

endinterface

// File: rtl/uart_gap_timer.sv
// Clear/enable counter with a flag at its limit. Wrap mode flags the last
// enabled cycle before Limit (timeout strobe); saturating mode holds at Limit
// and flags it for as long as it stays there.
module uart_gap_timer #(
  parameter int unsigned Limit    = 100,
  parameter bit          Saturate = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic hit_o
);

  localparam int unsigned Width = $clog2(Limit + 1);
  localparam logic [Width-1:0] LastVal = Width'(Limit - 1);
  localparam logic [Width-1:0] TopVal  = Width'(Limit);

  logic [Width-1:0] count_d, count_q;

  // Next count: clear has priority, then wrap after the last value or hold at the top.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      if (Saturate) begin
        if (count_q != TopVal) count_d = count_q + 1'b1;
      end else if (count_q == LastVal) begin
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign hit_o = Saturate ? (count_q == TopVal) : (enable_i && (count_q == LastVal));

endmodule

// File: rtl/uart_frame_rx.sv
// Rebuilds the 4-byte pong link frame from the UART byte stream, checks the
// marker and inter-byte gap, publishes the frame and tracks link liveness.
module uart_frame_rx #(
  parameter int unsigned GAP_CYCLES   = 200_000,
  parameter int unsigned LINK_TIMEOUT = 8_000_000
) (
  input logic             clk,
  input logic             rst_n,
  uart_frame_rx_if.slave  bus
);
  import pong_link_pkg::*;

  rx_state_e   state_d, state_q;
  logic [1:0]  idx_d, idx_q;
  logic [31:0] shadow_d, shadow_q;
  logic [31:0] rx_buf_d, rx_buf_q;
  logic        valid_d, valid_q;
  logic        err_d, err_q;
  logic        err_pend_d, err_pend_q;
  logic        seen_d, seen_q;
  logic        link_up_d, link_up_q;
  logic        gap_hit, link_hit;

  uart_gap_timer #(
    .Limit    (GAP_CYCLES),
    .Saturate (1'b0)
  ) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (bus.rx_done),
    .enable_i (state_q == COLLECT),
    .hit_o    (gap_hit)
  );

  // Cleared in the PUBLISH cycle, i.e. on the same edge that raises frame_valid.
  uart_gap_timer #(
    .Limit    (LINK_TIMEOUT),
    .Saturate (1'b1)
  ) u_link_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (state_q == PUBLISH),
    .enable_i (1'b1),
    .hit_o    (link_hit)
  );

  // Next-state and registered-output logic of the frame FSM.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    rx_buf_d   = rx_buf_q;
    valid_d    = 1'b0;
    err_d      = err_pend_q;
    err_pend_d = 1'b0;
    seen_d     = seen_q;
    link_up_d  = seen_q && !link_hit;
    unique case (state_q)
      IDLE, PUBLISH: begin
        if (state_q == PUBLISH) begin
          rx_buf_d = shadow_q;
          valid_d  = 1'b1;
          seen_d   = 1'b1;
          state_d  = IDLE;
        end
        if (bus.rx_done) begin
          if (bus.rx_data[MARKER_BIT]) begin
            shadow_d = {24'h0, bus.rx_data};
            idx_d    = 2'd1;
            state_d  = COLLECT;
          end else if (state_q == PUBLISH) begin
            // Defer the error one cycle so it never overlaps frame_valid.
            err_pend_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (bus.rx_done) begin
          shadow_d = {shadow_q[23:0], bus.rx_data};
          idx_d    = idx_q + 2'd1;
          if (idx_q == 2'(FRAME_BYTES - 1)) state_d = PUBLISH;
        end else if (gap_hit) begin
          err_d    = 1'b1;
          shadow_d = '0;
          idx_d    = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Single state/output register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      shadow_q   <= '0;
      rx_buf_q   <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
      seen_q     <= 1'b0;
      link_up_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      rx_buf_q   <= rx_buf_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      err_pend_q <= err_pend_d;
      seen_q     <= seen_d;
      link_up_q  <= link_up_d;
    end
  end

  assign bus.rx_buf      = rx_buf_q;
  assign bus.y_player2   = rx_buf_q[Y_P2_MSB:Y_P2_LSB];
  assign bus.y_ball      = rx_buf_q[Y_BALL_MSB:Y_BALL_LSB];
  assign bus.x_ball      = rx_buf_q[X_BALL_MSB:X_BALL_LSB];
  assign bus.frame_valid = valid_q;
  assign bus.frame_err   = err_q;
  assign bus.link_up     = link_up_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Randomized bench for uart_frame_rx with an event-schedule reference model
// plus directed scenarios for the documented corner cases.
module tb_uart_frame_rx;

  localparam int unsigned GAP  = 100;
  localparam int unsigned LINK = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  uart_frame_rx_if bus ();

  uart_frame_rx #(
    .GAP_CYCLES   (GAP),
    .LINK_TIMEOUT (LINK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_valid_seen = 0;
  int n_err_seen   = 0;

  // Reference model: frames and errors are scheduled as absolute cycle events.
  bit          in_frame;
  int          last_rx;
  logic [7:0]  got_q[$];
  bit          valid_at[int];
  logic [31:0] valid_val[int];
  bit          err_at[int];
  logic [31:0] cur_buf;
  bit          has_valid;
  int          last_v;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    in_frame = 1'b0;
    got_q.delete();
    valid_at.delete();
    valid_val.delete();
    err_at.delete();
    cur_buf   = '0;
    has_valid = 1'b0;
    last_v    = 0;
  endtask

  // Error pulses may never share a cycle with a frame pulse; they slip by one.
  task automatic sched_err(input int t);
    if (valid_at.exists(t)) t++;
    err_at[t] = 1'b1;
  endtask

  task automatic model_cycle(input int c, input bit done, input logic [7:0] d);
    if (in_frame && !done && (c - last_rx) == int'(GAP)) begin
      in_frame = 1'b0;
      got_q.delete();
      sched_err(c + 1);
    end
    if (done) begin
      if (in_frame) begin
        got_q.push_back(d);
        last_rx = c;
        if (got_q.size() == 4) begin
          valid_at[c + 2]  = 1'b1;
          valid_val[c + 2] = {got_q[0], got_q[1], got_q[2], got_q[3]};
          in_frame = 1'b0;
          got_q.delete();
        end
      end else if (d[7]) begin
        in_frame = 1'b1;
        got_q.push_back(d);
        last_rx = c;
      end else begin
        sched_err(c + 1);
      end
    end
  endtask

  task automatic check_cycle();
    int c        = cyc;
    bit link_exp = has_valid && ((c - 1 - last_v) < int'(LINK));
    bit v_exp    = valid_at.exists(c);
    if (v_exp) begin
      cur_buf   = valid_val[c];
      has_valid = 1'b1;
      last_v    = c;
    end
    if (bus.frame_valid === 1'b1) n_valid_seen++;
    if (bus.frame_err === 1'b1)   n_err_seen++;
    check_eq("frame_valid", 32'(bus.frame_valid), 32'(v_exp));
    check_eq("frame_err", 32'(bus.frame_err), 32'(err_at.exists(c)));
    check_eq("link_up", 32'(bus.link_up), 32'(link_exp));
    check_eq("rx_buf", bus.rx_buf, cur_buf);
    if (v_exp) begin
      check_eq("y_player2", 32'(bus.y_player2), 32'(cur_buf[30:21]));
      check_eq("y_ball", 32'(bus.y_ball), 32'(cur_buf[20:11]));
      check_eq("x_ball", 32'(bus.x_ball), 32'(cur_buf[10:0]));
    end
  endtask

  task automatic step(input bit done, input logic [7:0] d);
    bus.rx_done = done;
    bus.rx_data = d;
    model_cycle(cyc, done, d);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'($urandom));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_before);
    idle(gap_before);
    step(1'b1, b);
  endtask

  task automatic send_frame(input logic [31:0] f, input int gap);
    send_byte(f[31:24], gap);
    send_byte(f[23:16], gap);
    send_byte(f[15:8], gap);
    send_byte(f[7:0], gap);
  endtask

  task automatic check_zero(input string pfx);
    check_eq({pfx, "_rx_buf"}, bus.rx_buf, 32'h0);
    check_eq({pfx, "_fields"}, {bus.y_player2, bus.y_ball, bus.x_ball}, 32'h0);
    check_eq({pfx, "_flags"}, {29'h0, bus.frame_valid, bus.frame_err, bus.link_up}, 32'h0);
  endtask

  task automatic apply_reset();
    bus.rx_done = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero("rst_now");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("rst_hold");
    rst_n = 1'b1;
  endtask

  int          v0, e0, g, r;
  logic [7:0]  b;

  initial begin
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    model_reset();
    apply_reset();
    idle(5);

    // Reference frame with 10-cycle byte spacing.
    v0 = n_valid_seen;
    send_frame(32'hA35C812F, 9);
    check_eq("t1_latency", 32'(bus.frame_valid), 32'd0);
    idle(1);
    check_eq("t1_valid", 32'(bus.frame_valid), 32'd1);
    check_eq("t1_rx_buf", bus.rx_buf, 32'hA35C812F);
    check_eq("t1_y_player2", 32'(bus.y_player2), 32'h11A);
    check_eq("t1_y_ball", 32'(bus.y_ball), 32'h390);
    check_eq("t1_x_ball", 32'(bus.x_ball), 32'h12F);
    check_eq("t1_link_pre", 32'(bus.link_up), 32'd0);
    idle(1);
    check_eq("t1_link", 32'(bus.link_up), 32'd1);
    idle(5);
    check_eq("t1_pulses", 32'(n_valid_seen - v0), 32'd1);

    // Unmarked leading byte, then a good frame.
    v0 = n_valid_seen; e0 = n_err_seen;
    send_byte(8'h12, 3);
    send_frame(32'h80000005, 4);
    idle(5);
    check_eq("t2_err", 32'(n_err_seen - e0), 32'd1);
    check_eq("t2_valid", 32'(n_valid_seen - v0), 32'd1);
    check_eq("t2_rx_buf", bus.rx_buf, 32'h80000005);

    // Inter-byte gap expiry keeps the previous frame.
    e0 = n_err_seen;
    send_byte(8'h80, 3);
    send_byte(8'h11, 3);
    idle(105);
    check_eq("t3_err", 32'(n_err_seen - e0), 32'd1);
    check_eq("t3_rx_buf", bus.rx_buf, 32'h80000005);
    send_frame(32'hC0FFEE01, 6);
    idle(3);
    check_eq("t3_next", bus.rx_buf, 32'hC0FFEE01);

    // Bytes landing exactly on the expiry cycle are accepted.
    v0 = n_valid_seen; e0 = n_err_seen;
    send_frame(32'h9F123456, int'(GAP) - 1);
    idle(4);
    check_eq("t4_err", 32'(n_err_seen - e0), 32'd0);
    check_eq("t4_valid", 32'(n_valid_seen - v0), 32'd1);
    check_eq("t4_rx_buf", bus.rx_buf, 32'h9F123456);

    // Link timeout and recovery.
    idle(int'(LINK) + 5);
    check_eq("t5_link_down", 32'(bus.link_up), 32'd0);
    send_frame(32'hABCDEF12, 2);
    idle(3);
    check_eq("t5_link_up", 32'(bus.link_up), 32'd1);

    // Next frame starting in the publish cycle, then a bad byte there.
    send_frame(32'h85010203, 2);
    send_frame(32'h86040506, 0);
    idle(3);
    check_eq("t7_back2back", bus.rx_buf, 32'h86040506);
    v0 = n_valid_seen; e0 = n_err_seen;
    send_frame(32'h87070809, 1);
    send_byte(8'h33, 0);
    idle(4);
    check_eq("t7_err", 32'(n_err_seen - e0), 32'd1);
    check_eq("t7_valid", 32'(n_valid_seen - v0), 32'd1);

    // Reset in the middle of a frame.
    send_byte(8'h80, 2);
    send_byte(8'h22, 2);
    apply_reset();
    v0 = n_valid_seen;
    send_frame(32'hC1020304, 3);
    idle(4);
    check_eq("t6_rx_buf", bus.rx_buf, 32'hC1020304);
    check_eq("t6_valid", 32'(n_valid_seen - v0), 32'd1);

    // Random byte stream with gaps clustered around the expiry boundary.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8)       g = int'($urandom_range(GAP - 5, GAP + 10));
      else if (r < 14) g = 0;
      else             g = int'($urandom_range(0, 12));
      b    = 8'($urandom);
      b[7] = ($urandom_range(0, 9) < 7);
      send_byte(b, g);
    end
    idle(int'(GAP) + 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
